// File: rtl/outport_uart_tx_if.sv
// CPU-side output-port bus: write strobe/data, overflow clear, status and the serial line.
interface outport_uart_tx_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        clr_ovf;
  logic        full;
  logic        busy;
  logic        overflow;
  logic        tx;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  full, busy, overflow, tx
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output full, busy, overflow, tx
  );
endinterface

// File: rtl/outport_uart_tx.sv
// Output-port UART transmitter: word FIFO feeding four 8-N-1 frames per word, LSB byte first.
module outport_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH        = 4
) (
  input  logic              clk,
  input  logic              rst,
  outport_uart_tx_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   shift_q, shift_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          tx_q, tx_d;
  logic [31:0]   mem [DEPTH];

  logic          push_c, pop_c, drop_c, bit_end_c;
  logic [7:0]    cur_byte_c;

  // Full is judged on the pre-edge count, so a write on a pop edge while full is still dropped.
  assign push_c    = bus.wr_en & ~full_q;
  assign drop_c    = bus.wr_en & full_q;
  assign pop_c     = (state_q == IDLE) && (count_q != '0);
  assign bit_end_c = (baud_q == BAUD_LAST);

  // Next-state, datapath and status computation.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    cur_byte_c = 8'h00;

    case (state_q)
      IDLE: begin
        if (pop_c) begin
          state_d = START;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          shift_d = mem[rd_ptr_q];
        end
      end
      START: begin
        if (bit_end_c) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            shift_d = {8'h00, shift_q[31:8]};
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx stays aligned with the state register.
    cur_byte_c = shift_d[7:0];
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte_c[bit_d];
      default: tx_d = 1'b1;
    endcase

    wr_ptr_d = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    full_d = (count_d == FULL_CNT);
    busy_d = (count_d != '0) || (state_d != IDLE);
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State and status registers; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.full     = full_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;
  assign bus.tx       = tx_q;

endmodule

// File: tb/tb_outport_uart_tx.sv
// Scoreboard bench: a word-timeline model predicts frames and status, a line receiver checks them.
module tb_outport_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int WORD_CYC = 40 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;

  outport_uart_tx_if bus();

  outport_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         st;
  } exp_t;

  logic [31:0] mq[$];
  exp_t        eq[$];
  int          cyc     = 0;
  int          tx_free = 0;
  bit          m_ovf   = 1'b0;
  int          checks  = 0;
  int          errors  = 0;

  bit          rx_active = 1'b0;
  int          rx_start;
  int          rx_s;
  bit          glitch;
  logic [9:0]  rx_bits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a word is popped when the line is free; it occupies 40 bit times plus one idle cycle.
  always @(posedge clk or negedge rst) begin : model_p
    int pre;
    logic [31:0] w;
    if (!rst) begin
      mq.delete();
      eq.delete();
      tx_free = 0;
      m_ovf   = 1'b0;
    end else begin
      cyc++;
      pre = mq.size();
      if (pre > 0 && cyc >= tx_free) begin
        w = mq.pop_front();
        for (int k = 0; k < 4; k++) begin
          exp_t e;
          e.b  = w[8*k +: 8];
          e.st = cyc + k * 10 * CPB;
          eq.push_back(e);
        end
        tx_free = cyc + WORD_CYC + 1;
      end
      if (bus.wr_en) begin
        if (pre == DEPTH) m_ovf = 1'b1;
        else mq.push_back(bus.wr_data);
      end
      if (!(bus.wr_en && pre == DEPTH) && bus.clr_ovf) m_ovf = 1'b0;
    end
  end

  // Line receiver and status monitor, sampling mid-cycle.
  always @(negedge clk) begin : mon_p
    int bi;
    exp_t e;
    if (!rst) begin
      rx_active = 1'b0;
    end else begin
      if (!rx_active && bus.tx === 1'b0) begin
        rx_active = 1'b1;
        rx_start  = cyc;
        rx_s      = 0;
        glitch    = 1'b0;
        rx_bits   = '0;
      end
      if (rx_active) begin
        bi = rx_s / CPB;
        if (rx_s % CPB == 0) rx_bits[bi] = bus.tx;
        else if (bus.tx !== rx_bits[bi]) glitch = 1'b1;
        rx_s++;
        if (rx_s == 10 * CPB) begin
          rx_active = 1'b0;
          if (eq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %0h with nothing expected (cycle %0d)", rx_bits[8:1], cyc);
          end else begin
            e = eq.pop_front();
            chk("frame_byte", 32'(rx_bits[8:1]), 32'(e.b));
            chk("frame_start_cycle", 32'(rx_start), 32'(e.st));
            chk("frame_shape", {29'd0, glitch, rx_bits[0], rx_bits[9]}, 32'd1);
          end
        end
      end
      chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      chk("busy", 32'(bus.busy), 32'((mq.size() > 0) || (cyc < tx_free - 1)));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    end
  end

  task automatic put(input bit we, input logic [31:0] d, input bit c);
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.clr_ovf = c;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (mq.size() == 0 && eq.size() == 0 && !rx_active && cyc >= tx_free) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: still busy after %0d cycles, %0d bytes pending", limit, eq.size());
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(bus.tx), 32'd1);
    chk("reset_full", 32'(bus.full), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single word.
    put(1, 32'h44332211, 0);
    put(0, 0, 0);
    wait_idle(400);

    // Fill and overflow, then clear priority.
    for (int i = 0; i < 6; i++) put(1, 32'hA0 + 32'(i), 0);
    put(1, 32'hB0, 1);
    put(0, 0, 1);
    put(0, 0, 0);
    wait_idle(1200);

    // Back-to-back words.
    put(1, 32'h000000FF, 0);
    put(1, 32'h0000FF00, 0);
    put(0, 0, 0);
    wait_idle(600);

    // Reset during DATA bit 3 of byte 1 with two words queued.
    put(1, 32'h12345678, 0);
    put(1, 32'h9ABCDEF0, 0);
    put(0, 0, 0);
    repeat (14 * CPB) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_tx", 32'(bus.tx), 32'd1);
    chk("midreset_busy", 32'(bus.busy), 32'd0);
    chk("midreset_full", 32'(bus.full), 32'd0);
    chk("midreset_overflow", 32'(bus.overflow), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) bad++;
    end
    chk("idle_after_reset", 32'(bad), 32'd0);

    // Random traffic with occasional overflow clears.
    for (int i = 0; i < 3000; i++)
      put($urandom_range(0, 99) < 2, $urandom, $urandom_range(0, 29) == 0);

    // Continuous writes while full so pops coincide with dropped writes.
    for (int i = 0; i < 400; i++) put(1, $urandom, 0);
    put(0, 0, 1);
    put(0, 0, 0);
    wait_idle(1200);
    chk("scoreboard_empty", 32'(eq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
